fifo_sync_flags: RTL and testbench

Parametrised single-clock FIFO that succeeds the basic push/pop buffer used in the BPSK transmitter data path. It adds:
- arbitrary (non power-of-two) depth
- an occupancy count
- programmable almost-full and almost-empty thresholds
- a synchronous flush

It sits between the byte/symbol source and the modulator framing logic, and absorbs bursts without upstream stalls.

---
 rtl/fifo_sync_flags.sv | 78 +++++++
 tb/tb_fifo_sync_flags.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO, any depth, count and threshold flags; define FIFO_ERR_FLAGS_EN for sticky overflow/underflow
module fifo_sync_flags #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic             clr_err,
    output logic             overflow,
    output logic             underflow,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic pop_ok, push_ok;
    always_comb begin
        pop_ok   = pop & (count_q != '0);
        push_ok  = push & ((count_q != CNT_W'(DEPTH)) | pop_ok);
        wr_ptr_d = flush ? '0 : !push_ok ? wr_ptr_q : wr_ptr_q == PTR_W'(DEPTH - 1) ? '0 : wr_ptr_q + PTR_W'(1);
        rd_ptr_d = flush ? '0 : !pop_ok ? rd_ptr_q : rd_ptr_q == PTR_W'(DEPTH - 1) ? '0 : rd_ptr_q + PTR_W'(1);
        count_d  = flush ? '0 : (push_ok & ~pop_ok) ? count_q + CNT_W'(1) :
                   (pop_ok & ~push_ok) ? count_q - CNT_W'(1) : count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    // A push at full with a pop lands in the slot the pop frees, since wr_ptr == rd_ptr there.
    always_ff @(posedge clk)
        if (push_ok & ~flush & ~rst) mem[wr_ptr_q] <= data_in;
    assign data_out     = mem[rd_ptr_q];
    assign count        = count_q;
    assign valid        = count_q != '0;
    assign full         = count_q == CNT_W'(DEPTH);
    assign almost_full  = count_q >= CNT_W'(AF_THRESH);
    assign almost_empty = count_q <= CNT_W'(AE_THRESH);
`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;
    always_comb begin
        overflow_d  = clr_err ? 1'b0 : overflow_q | (push & ~push_ok);
        underflow_d = clr_err ? 1'b0 : underflow_q | (pop & ~pop_ok);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: vector table, corner sequences and random traffic against a queue model
module tb_fifo_sync_flags;
    logic clk = 1'b0;
    logic rst, push, pop, flush;
    logic [7:0] din, dout0, dout1;
    logic v0, v1, f0, f1, af0, af1, ae0, ae1;
    logic [4:0] cnt0;
    logic [2:0] cnt1;
`ifdef FIFO_ERR_FLAGS_EN
    logic clr_err, ovf0, unf0, ovf1, unf1;
`endif
    int passed = 0, total = 0;
    logic [7:0] q [2][$];
    bit mo [2], mu [2];
    int dep [2] = '{16, 5};
    int afth [2] = '{14, 4};
    always #5 clk = ~clk;

    fifo_sync_flags #(.DEPTH(16), .WIDTH(8)) u0 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .data_in(din),
`ifdef FIFO_ERR_FLAGS_EN
        .clr_err(clr_err), .overflow(ovf0), .underflow(unf0),
`endif
        .data_out(dout0), .valid(v0), .full(f0), .almost_full(af0), .almost_empty(ae0), .count(cnt0));
    fifo_sync_flags #(.DEPTH(5), .WIDTH(8), .AF_THRESH(4), .AE_THRESH(1)) u1 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .data_in(din),
`ifdef FIFO_ERR_FLAGS_EN
        .clr_err(clr_err), .overflow(ovf1), .underflow(unf1),
`endif
        .data_out(dout1), .valid(v1), .full(f1), .almost_full(af1), .almost_empty(ae1), .count(cnt1));

    typedef struct {
        bit pu, po, fl;
        logic [7:0] d;
        int cnt;
        bit v, f, af, ae;
        logic [7:0] dout;
    } vec_t;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    task automatic check_model();
        for (int id = 0; id < 2; id++) begin
            int n = q[id].size();
            chk($sformatf("d%0d count", id), id ? int'(cnt1) : int'(cnt0), n);
            chk($sformatf("d%0d valid", id), id ? int'(v1) : int'(v0), int'(n != 0));
            chk($sformatf("d%0d full", id), id ? int'(f1) : int'(f0), int'(n == dep[id]));
            chk($sformatf("d%0d almost_full", id), id ? int'(af1) : int'(af0), int'(n >= afth[id]));
            chk($sformatf("d%0d almost_empty", id), id ? int'(ae1) : int'(ae0), int'(n <= 1));
            if (n != 0) chk($sformatf("d%0d data_out", id), id ? int'(dout1) : int'(dout0), int'(q[id][0]));
`ifdef FIFO_ERR_FLAGS_EN
            chk($sformatf("d%0d overflow", id), id ? int'(ovf1) : int'(ovf0), int'(mo[id]));
            chk($sformatf("d%0d underflow", id), id ? int'(unf1) : int'(unf0), int'(mu[id]));
`endif
        end
    endtask

    task automatic cycle(bit pu, bit po, bit fl, logic [7:0] d, bit ce = 1'b0);
        push = pu; pop = po; flush = fl; din = d;
`ifdef FIFO_ERR_FLAGS_EN
        clr_err = ce;
`endif
        @(posedge clk);
        for (int id = 0; id < 2; id++) begin
            bit pok = po && q[id].size() != 0;
            bit puk = pu && (q[id].size() != dep[id] || pok);
            if (rst) begin
                q[id].delete(); mo[id] = 0; mu[id] = 0;
            end else begin
                mo[id] = ce ? 1'b0 : mo[id] | (pu & !puk);
                mu[id] = ce ? 1'b0 : mu[id] | (po & !pok);
                if (fl) q[id].delete();
                else begin
                    if (pok) void'(q[id].pop_front());
                    if (puk) q[id].push_back(d);
                end
            end
        end
        #1;
        check_model();
    endtask

    initial begin
        vec_t tbl [10];
        tbl[0] = '{1, 0, 0, 8'h11, 1, 1, 0, 0, 1, 8'h11};
        tbl[1] = '{1, 0, 0, 8'h22, 2, 1, 0, 0, 0, 8'h11};
        tbl[2] = '{1, 1, 0, 8'h33, 2, 1, 0, 0, 0, 8'h22};
        tbl[3] = '{0, 1, 0, 8'h00, 1, 1, 0, 0, 1, 8'h33};
        tbl[4] = '{0, 1, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00};
        tbl[5] = '{0, 1, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00};
        tbl[6] = '{1, 1, 0, 8'h3C, 1, 1, 0, 0, 1, 8'h3C};
        tbl[7] = '{1, 0, 1, 8'h44, 0, 0, 0, 0, 1, 8'h00};
        tbl[8] = '{1, 0, 0, 8'h55, 1, 1, 0, 0, 1, 8'h55};
        tbl[9] = '{1, 0, 0, 8'h66, 2, 1, 0, 0, 0, 8'h55};
        rst = 1;
        cycle(0, 0, 0, 8'h00);
        cycle(1, 1, 0, 8'hFF);
        chk("reset count", int'(cnt0), 0);
        chk("reset valid", int'(v0), 0);
        chk("reset full", int'(f0), 0);
        chk("reset almost_empty", int'(ae0), 1);
        chk("reset almost_full", int'(af0), 0);
        rst = 0;
        foreach (tbl[i]) begin
            cycle(tbl[i].pu, tbl[i].po, tbl[i].fl, tbl[i].d);
            chk($sformatf("vec%0d count", i), int'(cnt0), tbl[i].cnt);
            chk($sformatf("vec%0d valid", i), int'(v0), int'(tbl[i].v));
            chk($sformatf("vec%0d full", i), int'(f0), int'(tbl[i].f));
            chk($sformatf("vec%0d almost_full", i), int'(af0), int'(tbl[i].af));
            chk($sformatf("vec%0d almost_empty", i), int'(ae0), int'(tbl[i].ae));
            if (tbl[i].v) chk($sformatf("vec%0d data_out", i), int'(dout0), int'(tbl[i].dout));
        end
`ifdef FIFO_ERR_FLAGS_EN
        chk("underflow after empty pop", int'(unf0), 1);
`endif
        cycle(0, 0, 1, 8'h00);
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 0, 8'(i));
            chk("fill almost_full", int'(af0), int'(i + 1 >= 14));
            chk("fill full", int'(f0), int'(i == 15));
        end
        cycle(1, 1, 0, 8'hA5);
        chk("full push+pop count", int'(cnt0), 16);
        chk("full push+pop head", int'(dout0), 8'h01);
        cycle(1, 0, 0, 8'h77);
        chk("overflow push count", int'(cnt0), 16);
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow flag", int'(ovf0), 1);
`endif
        for (int i = 0; i < 16; i++) begin
            chk("drain order", int'(dout0), i == 15 ? 8'hA5 : i + 1);
            cycle(0, 1, 0, 8'h00);
        end
        chk("drained valid", int'(v0), 0);
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, 8'(8'h80 + i));
        chk("pre-flush count", int'(cnt0), 7);
        cycle(1, 0, 1, 8'h99);
        chk("flush count", int'(cnt0), 0);
        chk("flush valid", int'(v0), 0);
        cycle(1, 0, 0, 8'h12);
        chk("post-flush head", int'(dout0), 8'h12);
        cycle(0, 0, 1, 8'h00);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) begin
                cycle(1, 0, 0, 8'(r * 16 + k));
                chk("d5 almost_full", int'(af1), int'(k + 1 >= 4));
                chk("d5 full", int'(f1), int'(k == 4));
            end
            for (int k = 0; k < 5; k++) begin
                chk("d5 wrap order", int'(dout1), r * 16 + k);
                cycle(0, 1, 0, 8'h00);
                chk("d5 almost_empty", int'(ae1), int'(4 - k <= 1));
            end
        end
        cycle(0, 0, 0, 8'h00, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            int bias = (i / 300) % 3;
            bit pu = $urandom_range(0, 9) < (bias == 0 ? 7 : bias == 1 ? 3 : 5);
            bit po = $urandom_range(0, 9) < (bias == 0 ? 3 : bias == 1 ? 7 : 5);
            cycle(pu, po, $urandom_range(0, 59) == 0, 8'($urandom), $urandom_range(0, 99) == 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
